// File: rtl/speicher_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port (B) and the load/store port (D). It serves one access every four cycles.
module speicher_arbiter #(
    parameter int WORTBREITE = 32,
    parameter int WORTE      = 256,
    parameter int ADRESSBITS = $clog2(WORTE)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  B_Anfrage,
    input  logic [ADRESSBITS-1:0] B_Adresse,
    output logic [WORTBREITE-1:0] B_DatenRaus,
    output logic                  B_Fertig,
    input  logic                  D_Anfrage,
    input  logic                  D_SchreibenAn,
    input  logic [ADRESSBITS-1:0] D_Adresse,
    input  logic [WORTBREITE-1:0] D_DatenRein,
    output logic [WORTBREITE-1:0] D_DatenRaus,
    output logic                  D_Fertig,
    output logic                  RamSchreibenAn,
    output logic [ADRESSBITS-1:0] RamAdresse,
    output logic [WORTBREITE-1:0] RamDatenRein,
    input  logic [WORTBREITE-1:0] RamDatenRaus
);

    typedef enum logic [1:0] {FREI, ZUGRIFF, WARTEN, QUITTUNG} zustand_t;

    zustand_t zustand;
    logic     letzter_d;
    logic     gewaehlt_d;
    logic     schreiben;
    logic     wahl_d;

    // On a tie the port that did not win the previous grant gets the RAM.
    always_comb begin
        wahl_d = D_Anfrage && (!B_Anfrage || !letzter_d);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand        <= FREI;
            letzter_d      <= 1'b1;
            gewaehlt_d     <= 1'b0;
            schreiben      <= 1'b0;
            B_Fertig       <= 1'b0;
            D_Fertig       <= 1'b0;
            B_DatenRaus    <= '0;
            D_DatenRaus    <= '0;
            RamSchreibenAn <= 1'b0;
            RamAdresse     <= '0;
            RamDatenRein   <= '0;
        end else begin
            case (zustand)
                FREI: begin
                    if (B_Anfrage || D_Anfrage) begin
                        gewaehlt_d     <= wahl_d;
                        letzter_d      <= wahl_d;
                        schreiben      <= wahl_d && D_SchreibenAn;
                        RamSchreibenAn <= wahl_d && D_SchreibenAn;
                        RamAdresse     <= wahl_d ? D_Adresse : B_Adresse;
                        RamDatenRein   <= wahl_d ? D_DatenRein : '0;
                        zustand        <= ZUGRIFF;
                    end
                end
                ZUGRIFF: begin
                    RamSchreibenAn <= 1'b0;
                    zustand        <= WARTEN;
                end
                // Read data from the RAM is valid now; a store leaves DatenRaus untouched.
                WARTEN: begin
                    if (gewaehlt_d) begin
                        if (!schreiben) begin
                            D_DatenRaus <= RamDatenRaus;
                        end
                        D_Fertig <= 1'b1;
                    end else begin
                        B_DatenRaus <= RamDatenRaus;
                        B_Fertig    <= 1'b1;
                    end
                    zustand <= QUITTUNG;
                end
                QUITTUNG: begin
                    B_Fertig <= 1'b0;
                    D_Fertig <= 1'b0;
                    zustand  <= FREI;
                end
                default: begin
                    zustand <= FREI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speicher_arbiter.sv
// Self-checking bench for speicher_arbiter: a behavioural RAM plus a timeline
// model of accesses (grant cycle, +1 RAM access, +3 completion, +4 free again).
module tb_speicher_arbiter;

    localparam int WB  = 32;
    localparam int AB  = 8;
    localparam int NIE = 32'h7fffffff;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          B_Anfrage = 1'b0;
    logic [AB-1:0] B_Adresse = '0;
    logic [WB-1:0] B_DatenRaus;
    logic          B_Fertig;
    logic          D_Anfrage = 1'b0;
    logic          D_SchreibenAn = 1'b0;
    logic [AB-1:0] D_Adresse = '0;
    logic [WB-1:0] D_DatenRein = '0;
    logic [WB-1:0] D_DatenRaus;
    logic          D_Fertig;
    logic          RamSchreibenAn;
    logic [AB-1:0] RamAdresse;
    logic [WB-1:0] RamDatenRein;
    logic [WB-1:0] RamDatenRaus;

    always #5 Clock = ~Clock;

    speicher_arbiter #(.WORTBREITE(WB), .WORTE(256)) dut (
        .Clock(Clock), .Reset(Reset),
        .B_Anfrage(B_Anfrage), .B_Adresse(B_Adresse),
        .B_DatenRaus(B_DatenRaus), .B_Fertig(B_Fertig),
        .D_Anfrage(D_Anfrage), .D_SchreibenAn(D_SchreibenAn),
        .D_Adresse(D_Adresse), .D_DatenRein(D_DatenRein),
        .D_DatenRaus(D_DatenRaus), .D_Fertig(D_Fertig),
        .RamSchreibenAn(RamSchreibenAn), .RamAdresse(RamAdresse),
        .RamDatenRein(RamDatenRein), .RamDatenRaus(RamDatenRaus)
    );

    // Single-port RAM with one cycle read latency; the preload path is used only under reset.
    logic [WB-1:0] ram [0:255];
    logic          pre_en = 1'b0;
    logic [AB-1:0] pre_addr = '0;
    logic [WB-1:0] pre_data = '0;
    always @(posedge Clock) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (RamSchreibenAn === 1'b1) ram[RamAdresse] <= RamDatenRein;
        RamDatenRaus <= ram[RamAdresse];
    end

    int compared = 0;
    int mismatched = 0;

    logic [WB-1:0] ref_mem [0:255];
    int  cyc = 0;
    int  free_at = 0;
    bit  last_d = 1'b1;
    int  zug_cycle = -1;
    int  we_cycle = -1;
    int  fin_cycle = -1;
    bit  fin_d = 1'b0;
    bit  fin_rd = 1'b0;
    logic [WB-1:0] fin_val = '0;
    logic [AB-1:0] pend_addr = '0;
    logic [WB-1:0] pend_rdin = '0;
    int  b_done_at = NIE;
    int  d_done_at = NIE;
    bit  exp_bf = 1'b0;
    bit  exp_df = 1'b0;
    bit  exp_we = 1'b0;
    logic [WB-1:0] exp_bdat = '0;
    logic [WB-1:0] exp_ddat = '0;
    logic [AB-1:0] exp_radr = '0;
    logic [WB-1:0] exp_rdin = '0;

    // Move to the middle of the next cycle and work out what that cycle must show.
    task automatic advance();
        @(negedge Clock);
        cyc++;
        exp_we = (cyc == we_cycle);
        if (exp_we) ref_mem[pend_addr] = pend_rdin;
        if (cyc == zug_cycle) begin
            exp_radr = pend_addr;
            exp_rdin = pend_rdin;
        end
        exp_bf = (cyc == fin_cycle) && !fin_d;
        exp_df = (cyc == fin_cycle) && fin_d;
        if (cyc == fin_cycle && fin_rd) begin
            if (fin_d) exp_ddat = fin_val;
            else       exp_bdat = fin_val;
        end
    endtask

    // Apply this cycle's inputs to the model: reset, or a grant when the arbiter is free.
    task automatic accept();
        bit d;
        bit wr;
        logic [AB-1:0] a;
        if (Reset) begin
            fin_cycle = -1; we_cycle = -1; zug_cycle = -1;
            free_at = cyc + 1; last_d = 1'b1;
            exp_bdat = '0; exp_ddat = '0; exp_radr = '0; exp_rdin = '0;
            b_done_at = NIE; d_done_at = NIE;
        end else if (cyc >= free_at && (B_Anfrage || D_Anfrage)) begin
            d = D_Anfrage && (!B_Anfrage || !last_d);
            last_d = d;
            wr = d && D_SchreibenAn;
            a = d ? D_Adresse : B_Adresse;
            pend_addr = a;
            pend_rdin = d ? D_DatenRein : '0;
            zug_cycle = cyc + 1;
            we_cycle = wr ? cyc + 1 : -1;
            fin_cycle = cyc + 3;
            fin_d = d;
            fin_rd = !wr;
            fin_val = ref_mem[a];
            free_at = cyc + 4;
            if (d) d_done_at = cyc + 3;
            else   b_done_at = cyc + 3;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            advance();
            ref_mem[i] = (i == 0) ? 32'h80200001 : $urandom;
            pre_en = 1'b1; pre_addr = 8'(i); pre_data = ref_mem[i];
            accept();
        end
        advance();
        pre_en = 1'b0;
        compared += 7;
        if (B_Fertig !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bfertig got %b want 0", B_Fertig); end
        if (D_Fertig !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dfertig got %b want 0", D_Fertig); end
        if (B_DatenRaus !== '0) begin mismatched++; $display("[TB] FAIL reset_bdaten got %h want 0", B_DatenRaus); end
        if (D_DatenRaus !== '0) begin mismatched++; $display("[TB] FAIL reset_ddaten got %h want 0", D_DatenRaus); end
        if (RamSchreibenAn !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we got %b want 0", RamSchreibenAn); end
        if (RamAdresse !== '0) begin mismatched++; $display("[TB] FAIL reset_adr got %h want 0", RamAdresse); end
        if (RamDatenRein !== '0) begin mismatched++; $display("[TB] FAIL reset_rdin got %h want 0", RamDatenRein); end
        Reset = 1'b0;
        accept();
    endtask

    task automatic test_fetch();
        advance();
        B_Anfrage = 1'b1; B_Adresse = 8'h00;
        accept();
        for (int k = 1; k <= 5; k++) begin
            advance();
            compared += 3;
            if (B_Fertig !== (k == 3)) begin mismatched++; $display("[TB] FAIL fetch_bfertig k=%0d got %b want %b", k, B_Fertig, (k == 3)); end
            if (D_Fertig !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_dfertig k=%0d got %b want 0", k, D_Fertig); end
            if (RamSchreibenAn !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_we k=%0d got %b want 0", k, RamSchreibenAn); end
            if (k == 3) begin
                compared++;
                if (B_DatenRaus !== 32'h80200001) begin mismatched++; $display("[TB] FAIL fetch_daten got %h want 80200001", B_DatenRaus); end
            end
            if (k == 4) B_Anfrage = 1'b0;
            accept();
        end
    endtask

    task automatic test_store_load(input logic [AB-1:0] adr, input logic [WB-1:0] wert, input logic [WB-1:0] vorher);
        int we_count = 0;
        advance();
        D_Anfrage = 1'b1; D_SchreibenAn = 1'b1; D_Adresse = adr; D_DatenRein = wert;
        accept();
        for (int k = 1; k <= 8; k++) begin
            advance();
            if (RamSchreibenAn === 1'b1) we_count++;
            compared += 2;
            if (D_Fertig !== (k == 3 || k == 7)) begin mismatched++; $display("[TB] FAIL sl_dfertig k=%0d got %b want %b", k, D_Fertig, (k == 3 || k == 7)); end
            if (B_Fertig !== 1'b0) begin mismatched++; $display("[TB] FAIL sl_bfertig k=%0d got %b want 0", k, B_Fertig); end
            if (k == 1 || k == 5) begin
                compared++;
                if (RamAdresse !== adr) begin mismatched++; $display("[TB] FAIL sl_adr k=%0d got %h want %h", k, RamAdresse, adr); end
            end
            if (k == 1) begin
                compared += 2;
                if (RamDatenRein !== wert) begin mismatched++; $display("[TB] FAIL sl_rdin got %h want %h", RamDatenRein, wert); end
                if (RamSchreibenAn !== 1'b1) begin mismatched++; $display("[TB] FAIL sl_we_zugriff got %b want 1", RamSchreibenAn); end
            end
            if (k == 3) begin
                compared++;
                if (D_DatenRaus !== vorher) begin mismatched++; $display("[TB] FAIL sl_nach_store got %h want %h", D_DatenRaus, vorher); end
            end
            if (k == 7) begin
                compared++;
                if (D_DatenRaus !== wert) begin mismatched++; $display("[TB] FAIL sl_load got %h want %h", D_DatenRaus, wert); end
            end
            if (k == 4) begin D_SchreibenAn = 1'b0; D_DatenRein = $urandom; end
            if (k == 8) D_Anfrage = 1'b0;
            accept();
        end
        compared++;
        if (we_count != 1) begin mismatched++; $display("[TB] FAIL sl_we_count got %0d want 1", we_count); end
    endtask

    task automatic test_back_to_back();
        advance();
        B_Anfrage = 1'b1; B_Adresse = 8'($urandom);
        D_Anfrage = 1'b1; D_SchreibenAn = 1'($urandom); D_Adresse = 8'($urandom); D_DatenRein = $urandom;
        accept();
        for (int k = 1; k <= 32; k++) begin
            advance();
            compared += 5;
            if (B_Fertig !== (k % 8 == 3)) begin mismatched++; $display("[TB] FAIL b2b_bfertig k=%0d got %b want %b", k, B_Fertig, (k % 8 == 3)); end
            if (D_Fertig !== (k % 8 == 7)) begin mismatched++; $display("[TB] FAIL b2b_dfertig k=%0d got %b want %b", k, D_Fertig, (k % 8 == 7)); end
            if (B_DatenRaus !== exp_bdat) begin mismatched++; $display("[TB] FAIL b2b_bdaten k=%0d got %h want %h", k, B_DatenRaus, exp_bdat); end
            if (D_DatenRaus !== exp_ddat) begin mismatched++; $display("[TB] FAIL b2b_ddaten k=%0d got %h want %h", k, D_DatenRaus, exp_ddat); end
            if (RamSchreibenAn !== exp_we) begin mismatched++; $display("[TB] FAIL b2b_we k=%0d got %b want %b", k, RamSchreibenAn, exp_we); end
            if (k == 28) B_Anfrage = 1'b0;
            else if (k % 8 == 4) B_Adresse = 8'($urandom);
            if (k == 32) D_Anfrage = 1'b0;
            else if (k % 8 == 0) begin
                D_SchreibenAn = 1'($urandom); D_Adresse = 8'($urandom); D_DatenRein = $urandom;
            end
            accept();
        end
    endtask

    task automatic test_reset_warten();
        advance();
        B_Anfrage = 1'b1; B_Adresse = 8'($urandom);
        accept();
        for (int k = 1; k <= 7; k++) begin
            advance();
            if (k == 3) begin
                compared += 6;
                if (D_Fertig !== 1'b0) begin mismatched++; $display("[TB] FAIL rw_dfertig got %b want 0", D_Fertig); end
                if (B_DatenRaus !== '0) begin mismatched++; $display("[TB] FAIL rw_bdaten got %h want 0", B_DatenRaus); end
                if (D_DatenRaus !== '0) begin mismatched++; $display("[TB] FAIL rw_ddaten got %h want 0", D_DatenRaus); end
                if (RamSchreibenAn !== 1'b0) begin mismatched++; $display("[TB] FAIL rw_we got %b want 0", RamSchreibenAn); end
                if (RamAdresse !== '0) begin mismatched++; $display("[TB] FAIL rw_adr got %h want 0", RamAdresse); end
                if (RamDatenRein !== '0) begin mismatched++; $display("[TB] FAIL rw_rdin got %h want 0", RamDatenRein); end
            end
            compared++;
            if (B_Fertig !== (k == 6)) begin mismatched++; $display("[TB] FAIL rw_bfertig k=%0d got %b want %b", k, B_Fertig, (k == 6)); end
            if (k == 6) begin
                compared++;
                if (B_DatenRaus !== ref_mem[B_Adresse]) begin mismatched++; $display("[TB] FAIL rw_wiederholt got %h want %h", B_DatenRaus, ref_mem[B_Adresse]); end
            end
            Reset = (k == 2);
            if (k == 7) B_Anfrage = 1'b0;
            accept();
        end
    endtask

    task automatic test_reset_store();
        logic [AB-1:0] adr = 8'($urandom);
        logic [WB-1:0] wert = $urandom;
        advance();
        D_Anfrage = 1'b1; D_SchreibenAn = 1'b1; D_Adresse = adr; D_DatenRein = wert;
        accept();
        for (int k = 1; k <= 6; k++) begin
            advance();
            compared += 2;
            if (D_Fertig !== 1'b0) begin mismatched++; $display("[TB] FAIL rs_dfertig k=%0d got %b want 0", k, D_Fertig); end
            if (RamSchreibenAn !== (k == 1)) begin mismatched++; $display("[TB] FAIL rs_we k=%0d got %b want %b", k, RamSchreibenAn, (k == 1)); end
            if (k >= 2) begin
                compared++;
                if (B_Fertig !== (k == 5)) begin mismatched++; $display("[TB] FAIL rs_bfertig k=%0d got %b want %b", k, B_Fertig, (k == 5)); end
            end
            if (k == 5) begin
                compared++;
                if (B_DatenRaus !== wert) begin mismatched++; $display("[TB] FAIL rs_rueckgelesen got %h want %h", B_DatenRaus, wert); end
            end
            Reset = (k == 1);
            if (k == 2) begin
                D_Anfrage = 1'b0; D_SchreibenAn = 1'b0;
                B_Anfrage = 1'b1; B_Adresse = adr;
            end
            if (k == 6) B_Anfrage = 1'b0;
            accept();
        end
    endtask

    task automatic test_random();
        bit b_act = 1'b0;
        bit d_act = 1'b0;
        for (int i = 0; i < 600; i++) begin
            advance();
            compared += 7;
            if (B_Fertig !== exp_bf) begin mismatched++; $display("[TB] FAIL rnd_bfertig c=%0d got %b want %b", cyc, B_Fertig, exp_bf); end
            if (D_Fertig !== exp_df) begin mismatched++; $display("[TB] FAIL rnd_dfertig c=%0d got %b want %b", cyc, D_Fertig, exp_df); end
            if (B_DatenRaus !== exp_bdat) begin mismatched++; $display("[TB] FAIL rnd_bdaten c=%0d got %h want %h", cyc, B_DatenRaus, exp_bdat); end
            if (D_DatenRaus !== exp_ddat) begin mismatched++; $display("[TB] FAIL rnd_ddaten c=%0d got %h want %h", cyc, D_DatenRaus, exp_ddat); end
            if (RamSchreibenAn !== exp_we) begin mismatched++; $display("[TB] FAIL rnd_we c=%0d got %b want %b", cyc, RamSchreibenAn, exp_we); end
            if (RamAdresse !== exp_radr) begin mismatched++; $display("[TB] FAIL rnd_adr c=%0d got %h want %h", cyc, RamAdresse, exp_radr); end
            if (RamDatenRein !== exp_rdin) begin mismatched++; $display("[TB] FAIL rnd_rdin c=%0d got %h want %h", cyc, RamDatenRein, exp_rdin); end
            Reset = ($urandom_range(0, 149) == 0);
            if (b_act && cyc > b_done_at) b_act = 1'b0;
            if (d_act && cyc > d_done_at) d_act = 1'b0;
            if (!b_act) begin
                if ($urandom_range(0, 2) == 0) begin
                    b_act = 1'b1; b_done_at = NIE;
                    B_Anfrage = 1'b1; B_Adresse = 8'($urandom);
                end else B_Anfrage = 1'b0;
            end
            if (!d_act) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_act = 1'b1; d_done_at = NIE;
                    D_Anfrage = 1'b1; D_SchreibenAn = 1'($urandom);
                    D_Adresse = 8'($urandom); D_DatenRein = $urandom;
                end else D_Anfrage = 1'b0;
            end
            accept();
        end
        Reset = 1'b0; B_Anfrage = 1'b0; D_Anfrage = 1'b0;
        for (int i = 0; i < 8; i++) begin
            advance();
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load(8'h10, 32'hDEADBEEF, 32'h0);
        test_store_load(8'hFF, 32'hA5C3_0F1E, 32'hDEADBEEF);
        test_back_to_back();
        test_reset_warten();
        test_reset_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
